// File: rtl/b1_window_sampler.sv
// Aggregates b1 decode samples over fixed windows of WIN beats and queues one
// record per closed window (e/f hit counts, length, sticky error) in a FWFT FIFO.
module b1_window_sampler #(
    parameter int WIN   = 8,
    parameter int CW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_d,
    input  logic          in_e,
    input  logic          in_f,
    input  logic          in_g,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_e_cnt,
    output logic [CW-1:0] out_f_cnt,
    output logic [CW-1:0] out_len,
    output logic          out_err
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   WIN_C   = CW'(WIN);
    localparam logic [PW-1:0]   PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

    typedef enum logic {EMPTY, PARTIAL} state_t;

    typedef struct packed {
        logic [CW-1:0] e;
        logic [CW-1:0] f;
        logic [CW-1:0] n;
        logic          err;
    } rec_t;

    state_t state, state_nxt;

    logic [CW-1:0] e_acc, f_acc, n_acc;
    logic          err_acc;
    logic [CW-1:0] e_sum, f_sum, n_sum;
    logic          err_sum;

    rec_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;

    logic accept, push, pop, fifo_full, s_err;

    assign fifo_full = (count == CNT_MAX);
    assign in_ready  = ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign s_err     = (in_g == in_d) | (in_e & in_f);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // Window totals including this cycle's sample, so a closing push captures it.
    assign e_sum   = e_acc + CW'(accept & in_e);
    assign f_sum   = f_acc + CW'(accept & in_f);
    assign n_sum   = n_acc + CW'(accept);
    assign err_sum = err_acc | (accept & s_err);

    always_comb begin
        push      = 1'b0;
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (n_sum == WIN_C || flush) push = 1'b1;
                    else                         state_nxt = PARTIAL;
                end
            end
            PARTIAL: begin
                if (n_sum == WIN_C || (flush && !fifo_full)) begin
                    push      = 1'b1;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= EMPTY;
            e_acc   <= '0;
            f_acc   <= '0;
            n_acc   <= '0;
            err_acc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                e_acc   <= '0;
                f_acc   <= '0;
                n_acc   <= '0;
                err_acc <= 1'b0;
            end else begin
                e_acc   <= e_sum;
                f_acc   <= f_sum;
                n_acc   <= n_sum;
                err_acc <= err_sum;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{e: e_sum, f: f_sum, n: n_sum, err: err_sum};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_e_cnt = '0;
        out_f_cnt = '0;
        out_len   = '0;
        out_err   = 1'b0;
        if (out_valid) begin
            out_e_cnt = mem[rd_ptr].e;
            out_f_cnt = mem[rd_ptr].f;
            out_len   = mem[rd_ptr].n;
            out_err   = mem[rd_ptr].err;
        end
    end

    n_acc_bound: assert property (@(posedge clock) disable iff (reset) n_acc <= WIN_C);

endmodule
